// File: rtl/lane_mux_pkg.sv
// -----------------------------------------------------------------------------
// lane_mux_pkg
// Shared types and helpers for the N-to-1 lane serialiser.
//   state_t       : serialiser state (IDLE, SEND)
//   lane_hit_t    : result of a set-bit search (found flag + lane index)
//   clog2()       : index-width helper usable in parameter lists
//   next_set_bit(): lowest set mask bit at or above a starting lane
// -----------------------------------------------------------------------------
package lane_mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Searches run over a fixed-width mask; callers zero-extend narrower masks.
   localparam int MAX_LANES = 64;
   localparam int MAX_IDXW  = 6;

   typedef struct packed {
      logic                found;
      logic [MAX_IDXW-1:0] idx;
   } lane_hit_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Lowest set bit with index >= from. Scanning downwards lets the last
   // match written be the lowest one.
   function automatic lane_hit_t next_set_bit(input logic [MAX_LANES-1:0] mask,
                                              input int                   from);
      lane_hit_t hit;
      hit.found = 1'b0;
      hit.idx   = '0;
      for (int i = MAX_LANES - 1; i >= 0; i--) begin
         if ((i >= from) && mask[i]) begin
            hit.found = 1'b1;
            hit.idx   = MAX_IDXW'(i);
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/lane_next_finder.sv
// -----------------------------------------------------------------------------
// lane_next_finder
// Combinational lane-slot stepper shared by both compaction modes.
//   mask      in  : lanes eligible for output (all ones = visit every slot)
//   idx       in  : current lane index
//   next_idx  out : next eligible lane above idx (valid when is_last = 0)
//   first_idx out : lowest eligible lane in mask
//   is_last   out : no eligible lane above idx
//   any_set   out : mask has at least one eligible lane
// -----------------------------------------------------------------------------
module lane_next_finder
   import lane_mux_pkg::*;
#(
   parameter  int LANES = 4,
   localparam int IDXW  = clog2(LANES)
) (
   input  logic [LANES-1:0] mask,
   input  logic [IDXW-1:0]  idx,
   output logic [IDXW-1:0]  next_idx,
   output logic [IDXW-1:0]  first_idx,
   output logic             is_last,
   output logic             any_set
);

   logic [MAX_LANES-1:0] mask_wide;
   lane_hit_t            next_hit;
   lane_hit_t            first_hit;

   always_comb begin
      mask_wide              = '0;
      mask_wide[LANES-1:0]   = mask;
      next_hit               = next_set_bit(mask_wide, int'(idx) + 1);
      first_hit              = next_set_bit(mask_wide, 0);
      next_idx               = IDXW'(next_hit.idx);
      first_idx              = IDXW'(first_hit.idx);
      is_last                = ~next_hit.found;
      any_set                = first_hit.found;
   end

endmodule

// File: rtl/lane_mux_nto1_reg.sv
// -----------------------------------------------------------------------------
// lane_mux_nto1_reg
// Captures a LANES-wide group of WIDTH-bit words on load and serialises them,
// one lane per clk_nf cycle, on a registered output lane.
//   clk_nf    in  : fast clock, all logic on rising edge
//   reset     in  : asynchronous active-high reset
//   load      in  : capture valid_in/data_in (taken only while ready = 1)
//   valid_in  in  : per-lane valid bits
//   data_in   in  : packed lane words, lane 0 in the LSBs
//   ready     out : a load this cycle will be accepted
//   data_out  out : serialised word (zero when not valid)
//   valid_out out : data_out qualifies this cycle
//   lane_out  out : source lane of data_out (holds while idle)
//   overflow  out : sticky, set by a load while ready = 0
// COMPACT = 0 emits every lane slot; COMPACT = 1 skips lanes whose valid is 0.
// -----------------------------------------------------------------------------
module lane_mux_nto1_reg
   import lane_mux_pkg::*;
#(
   parameter  int LANES   = 4,
   parameter  int WIDTH   = 8,
   parameter  int COMPACT = 0,
   localparam int IDXW    = clog2(LANES)
) (
   input  logic                   clk_nf,
   input  logic                   reset,
   input  logic                   load,
   input  logic [LANES-1:0]       valid_in,
   input  logic [LANES*WIDTH-1:0] data_in,
   output logic                   ready,
   output logic [WIDTH-1:0]       data_out,
   output logic                   valid_out,
   output logic [IDXW-1:0]        lane_out,
   output logic                   overflow
);

   state_t           state_reg, state_next;
   logic [IDXW-1:0]  idx_reg, idx_next;
   logic [LANES-1:0] mask_reg, mask_next;
   logic [WIDTH-1:0] word_reg  [LANES];
   logic [WIDTH-1:0] word_next [LANES];

   logic [WIDTH-1:0] data_out_reg, data_out_next;
   logic             valid_out_reg, valid_out_next;
   logic [IDXW-1:0]  lane_out_reg, lane_out_next;
   logic             overflow_reg;

   logic             accept;

   // Stepping through the held group. Without compaction every slot is
   // visited, so the finder sees an all-ones mask.
   logic [LANES-1:0] step_mask;
   logic [IDXW-1:0]  step_next, step_first;
   logic             step_last, step_any;

   // First lane of the group being offered on the inputs right now.
   logic [IDXW-1:0]  cap_next, cap_first;
   logic             cap_last, cap_any;

   assign step_mask = (COMPACT != 0) ? mask_reg : {LANES{1'b1}};

   lane_next_finder #(.LANES(LANES)) u_step_finder (
      .mask      (step_mask),
      .idx       (idx_reg),
      .next_idx  (step_next),
      .first_idx (step_first),
      .is_last   (step_last),
      .any_set   (step_any)
   );

   lane_next_finder #(.LANES(LANES)) u_cap_finder (
      .mask      (valid_in),
      .idx       ({IDXW{1'b0}}),
      .next_idx  (cap_next),
      .first_idx (cap_first),
      .is_last   (cap_last),
      .any_set   (cap_any)
   );

   // Each finder instance only needs part of its result.
   logic unused_finder;
   assign unused_finder = ^{step_first, step_any, cap_next, cap_last};

   // The output registers always show the slot (state_reg, idx_reg), so
   // ready reflects whether the slot on the output right now is the last.
   assign ready  = (state_reg == IDLE) | ((state_reg == SEND) & step_last);
   assign accept = load & ready;

   // Next state / slot
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      mask_next  = mask_reg;
      if (accept) begin
         mask_next = valid_in;
         if ((COMPACT != 0) && !cap_any) begin
            // Empty compacted group: nothing to emit.
            state_next = IDLE;
         end else begin
            state_next = SEND;
            idx_next   = (COMPACT != 0) ? cap_first : '0;
         end
      end else if (state_reg == SEND) begin
         if (step_last) begin
            state_next = IDLE;
         end else begin
            idx_next = step_next;
         end
      end
   end

   // Holding register: a new group bypasses straight to the output register,
   // which gives the one-cycle load-to-first-word latency and lets a load on
   // the last slot follow without a bubble.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_word
      assign word_next[gi] = accept ? data_in[gi*WIDTH +: WIDTH] : word_reg[gi];

      always_ff @(posedge clk_nf or posedge reset) begin
         if (reset) begin
            word_reg[gi] <= '0;
         end else begin
            word_reg[gi] <= word_next[gi];
         end
      end
   end

   // Output slot contents for the slot about to be displayed. In compact
   // mode the selected mask bit is always set, so one rule serves both modes.
   always_comb begin
      valid_out_next = (state_next == SEND) & mask_next[idx_next];
      data_out_next  = valid_out_next ? word_next[idx_next] : '0;
      lane_out_next  = (state_next == SEND) ? idx_next : lane_out_reg;
   end

   always_ff @(posedge clk_nf or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         mask_reg      <= '0;
         data_out_reg  <= '0;
         valid_out_reg <= 1'b0;
         lane_out_reg  <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         mask_reg      <= mask_next;
         data_out_reg  <= data_out_next;
         valid_out_reg <= valid_out_next;
         lane_out_reg  <= lane_out_next;
         if (load && !ready) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign data_out  = data_out_reg;
   assign valid_out = valid_out_reg;
   assign lane_out  = lane_out_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_lane_mux_nto1_reg.sv
// -----------------------------------------------------------------------------
// tb_lane_mux_nto1_reg
// Drives one non-compacting and one compacting instance (LANES=4, WIDTH=8)
// from the same stimulus and compares both against a queue-based model of
// the slot stream each should produce.
// -----------------------------------------------------------------------------
module tb_lane_mux_nto1_reg;

   typedef struct {
      int lane;
      int data;
      bit vld;
   } slot_t;

   logic        clk_nf = 1'b0;
   logic        reset;
   logic        load;
   logic [3:0]  valid_in;
   logic [31:0] data_in;

   logic        rdy  [2];
   logic [7:0]  dout [2];
   logic        vout [2];
   logic [1:0]  lout [2];
   logic        ovf  [2];

   int n_checks = 0;
   int n_errors = 0;

   // Model: per instance, the slots still to be shown, front = on output now.
   slot_t mq [2][$];
   int    last_lane [2];
   bit    ovf_m [2];

   always #5 clk_nf = ~clk_nf;

   lane_mux_nto1_reg #(.LANES(4), .WIDTH(8), .COMPACT(0)) u_dut_full (
      .clk_nf    (clk_nf),
      .reset     (reset),
      .load      (load),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready     (rdy[0]),
      .data_out  (dout[0]),
      .valid_out (vout[0]),
      .lane_out  (lout[0]),
      .overflow  (ovf[0])
   );

   lane_mux_nto1_reg #(.LANES(4), .WIDTH(8), .COMPACT(1)) u_dut_cmp (
      .clk_nf    (clk_nf),
      .reset     (reset),
      .load      (load),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready     (rdy[1]),
      .data_out  (dout[1]),
      .valid_out (vout[1]),
      .lane_out  (lout[1]),
      .overflow  (ovf[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         last_lane[k] = 0;
         ovf_m[k]     = 1'b0;
      end
   endtask

   // One rising edge of the reference behaviour, using the inputs as seen now.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit can_take;
         can_take = (mq[k].size() <= 1);
         if (load && !can_take) ovf_m[k] = 1'b1;
         if (load && can_take) begin
            mq[k].delete();
            for (int i = 0; i < 4; i++) begin
               slot_t s;
               s.lane = i;
               s.vld  = valid_in[i];
               s.data = valid_in[i] ? int'(data_in[i*8 +: 8]) : 0;
               if (k == 0 || valid_in[i]) mq[k].push_back(s);
            end
            $display("load dut%0d t=%0t valid=%b data=%h slots=%0d", k, $time, valid_in, data_in, mq[k].size());
         end else if (mq[k].size() > 0) begin
            void'(mq[k].pop_front());
         end
         if (mq[k].size() > 0) last_lane[k] = mq[k][0].lane;
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int k = 0; k < 2; k++) begin
         int  e_data;
         bit  e_vld;
         e_data = 0;
         e_vld  = 1'b0;
         if (mq[k].size() > 0) begin
            e_data = mq[k][0].data;
            e_vld  = mq[k][0].vld;
         end
         check($sformatf("%s dut%0d ready", tag, k),     32'(rdy[k]),  32'(mq[k].size() <= 1));
         check($sformatf("%s dut%0d valid_out", tag, k), 32'(vout[k]), 32'(e_vld));
         check($sformatf("%s dut%0d data_out", tag, k),  32'(dout[k]), 32'(e_data));
         check($sformatf("%s dut%0d lane_out", tag, k),  32'(lout[k]), 32'(last_lane[k]));
         check($sformatf("%s dut%0d overflow", tag, k),  32'(ovf[k]),  32'(ovf_m[k]));
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk_nf);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input logic ld, input logic [3:0] v, input logic [31:0] d);
      load     = ld;
      valid_in = v;
      data_in  = d;
   endtask

   // Asynchronous reset raised between edges; outputs must clear at once.
   task automatic reset_mid(input string tag);
      #2;
      load  = 1'b0;
      reset = 1'b1;
      #1;
      model_clear();
      check_outputs(tag);
      @(posedge clk_nf);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 4'h0, 32'h0);
      model_clear();
      #7;
      check_outputs("por");
      #5;
      reset = 1'b0;

      // Full group, no compaction difference.
      drive(1'b1, 4'b1111, 32'h44332211);
      step("tp1");
      drive(1'b0, 4'b0000, 32'h0);
      for (int i = 0; i < 5; i++) step("tp1");

      // Sparse group.
      drive(1'b1, 4'b0101, 32'hDDCCBBAA);
      step("tp2");
      drive(1'b0, 4'b1010, 32'h12345678);
      for (int i = 0; i < 5; i++) step("tp2");

      // Empty group.
      drive(1'b1, 4'b0000, 32'h55667788);
      step("tp3");
      drive(1'b0, 4'b0000, 32'h0);
      for (int i = 0; i < 5; i++) step("tp3");

      // Back-to-back: B loaded while A's last slot is on the output.
      drive(1'b1, 4'b1111, 32'hA3A2A1A0);
      step("b2b");
      drive(1'b0, 4'b0000, 32'h0);
      for (int i = 0; i < 3; i++) step("b2b");
      drive(1'b1, 4'b1011, 32'hB3B2B1B0);
      step("b2b");
      drive(1'b0, 4'b0000, 32'h0);
      for (int i = 0; i < 5; i++) step("b2b");

      // Load while busy: ignored, overflow sticks.
      drive(1'b1, 4'b1111, 32'hC3C2C1C0);
      step("ovf");
      drive(1'b0, 4'b0000, 32'h0);
      step("ovf");
      drive(1'b1, 4'b1111, 32'hEEEEEEEE);
      step("ovf");
      drive(1'b0, 4'b0000, 32'h0);
      for (int i = 0; i < 6; i++) step("ovf");

      // Reset mid-group, then a fresh group.
      drive(1'b1, 4'b1111, 32'hF3F2F1F0);
      step("rst");
      drive(1'b0, 4'b0000, 32'h0);
      step("rst");
      reset_mid("rst_async");
      drive(1'b1, 4'b0110, 32'h90817263);
      step("rst");
      drive(1'b0, 4'b0000, 32'h0);
      for (int i = 0; i < 5; i++) step("rst");

      // Random traffic with occasional resets.
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(99) < 2) begin
            reset_mid("rnd_rst");
         end else begin
            logic [3:0] v;
            v = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
            drive(1'($urandom_range(99) < 45), v, $urandom);
            step("rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
